instr_fetch_register: RTL

Parametrised, multi-byte successor to the single-byte SAP instruction register. Assembles one instruction (opcode byte plus 0..MAX_OPERANDS operand bytes) from successive W-bus transfers and presents it as a whole. Raises instr_valid when assembly is complete and holds it until the control sequencer consumes it. Sits between the W bus and the control sequencer/decoder; the operand field also feeds the memory address path.

---
 rtl/instr_fetch_register_if.sv | 30 +++
 rtl/instr_fetch_register.sv | 102 ++++++++++
 2 files changed

// File: rtl/instr_fetch_register_if.sv
// W-bus side and sequencer side signals of the instruction fetch register.
// The master drives bytes, load/consume and addr_en; the slave is the register.
interface instr_fetch_register_if #(
  parameter int DATA_W       = 8,
  parameter int MAX_OPERANDS = 2,
  parameter int CNT_W        = 2,
  parameter int ADDR_W       = 16
);
  logic [DATA_W-1:0]              w_bus;
  logic                           load;
  logic [CNT_W-1:0]               operand_count;
  logic                           consume;
  logic                           addr_en;
  logic                           accept;
  logic                           instr_valid;
  logic [DATA_W-1:0]              opcode;
  logic [MAX_OPERANDS*DATA_W-1:0] operands;
  logic [ADDR_W-1:0]              addr_out;
  logic                           len_err;

  modport master (
    output w_bus, load, operand_count, consume, addr_en,
    input  accept, instr_valid, opcode, operands, addr_out, len_err
  );

  modport slave (
    input  w_bus, load, operand_count, consume, addr_en,
    output accept, instr_valid, opcode, operands, addr_out, len_err
  );
endinterface

// File: rtl/instr_fetch_register.sv
// Multi-byte instruction register: assembles an opcode plus up to MAX_OPERANDS
// operand bytes from the W bus and holds the complete instruction until the
// control sequencer consumes it.
module instr_fetch_register #(
  parameter int DATA_W       = 8,
  parameter int MAX_OPERANDS = 2,
  parameter int CNT_W        = 2,
  parameter int ADDR_W       = 16
) (
  input logic                    clk,
  input logic                    reset,
  instr_fetch_register_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OPERAND, READY} state_t;

  state_t                         state_q, state_d;
  logic [DATA_W-1:0]              opcode_q;
  logic [MAX_OPERANDS*DATA_W-1:0] operands_q;
  logic [CNT_W-1:0]               idx_q;
  logic [CNT_W-1:0]               len_q;
  logic [CNT_W-1:0]               len_clamped;
  logic                           len_err_q;
  logic                           over;
  logic                           last_operand;
  logic                           take_opcode;
  logic                           take_operand;

  // Oversized operand counts are clamped; the instruction still completes.
  assign over         = bus.operand_count > CNT_W'(MAX_OPERANDS);
  assign len_clamped  = over ? CNT_W'(MAX_OPERANDS) : bus.operand_count;
  assign last_operand = (idx_q == len_q - CNT_W'(1));

  // Next-state and capture strobes; a consume in READY frees the register in
  // the same edge, so a simultaneous load is treated as the next opcode.
  always_comb begin
    state_d      = state_q;
    take_opcode  = 1'b0;
    take_operand = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          take_opcode = 1'b1;
          state_d     = (len_clamped == '0) ? READY : OPERAND;
        end
      end
      OPERAND: begin
        if (bus.load) begin
          take_operand = 1'b1;
          if (last_operand) state_d = READY;
        end
      end
      READY: begin
        if (bus.consume) begin
          if (bus.load) begin
            take_opcode = 1'b1;
            state_d     = (len_clamped == '0) ? READY : OPERAND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Opcode/operand capture, operand index and sticky length error.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q   <= '0;
      operands_q <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      len_err_q  <= 1'b0;
    end else if (take_opcode) begin
      opcode_q   <= bus.w_bus;
      operands_q <= '0;
      idx_q      <= '0;
      len_q      <= len_clamped;
      if (over) len_err_q <= 1'b1;
    end else if (take_operand) begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        if (idx_q == CNT_W'(k)) operands_q[k*DATA_W +: DATA_W] <= bus.w_bus;
      end
      if (!last_operand) idx_q <= idx_q + CNT_W'(1);
    end
  end

  assign bus.accept      = (state_q != READY) | bus.consume;
  assign bus.instr_valid = (state_q == READY);
  assign bus.opcode      = opcode_q;
  assign bus.operands    = operands_q;
  assign bus.len_err     = len_err_q;
  assign bus.addr_out    = bus.addr_en ? operands_q[ADDR_W-1:0] : '0;

endmodule
